// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, active-low 7-segment patterns, screen size and BCD helpers
package pong_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;
  localparam int H_RES = 1024;
  localparam int V_RES = 768;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_G = 7'b0000010;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-low 7-segment pattern, blank for non-decimal codes
module seg7_decode
  import pong_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong game flow FSM - serve gating, per-frame step bursts, BCD scoring, win detect and score display
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int STEPS = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE = 11,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_n,
  input  logic       point_l,
  input  logic       point_r,
  output logic       step,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic       game_over,
  output logic [1:0] state,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [2:0] STEPS_LAST = 3'(STEPS - 1);
  localparam logic [7:0] WIN_BCD = to_bcd(WIN_SCORE);
  state_t st;
  logic s0, s1, s2, press;
  logic [7:0] serve_cnt, blink_cnt, l_score, r_score, l_inc, r_inc;
  logic [2:0] rem;
  logic show, win_left, blank_l, blank_r;
  logic [6:0] seg_lu, seg_lt, seg_ru, seg_rt;
  assign state = st;
  assign l_inc = bcd_inc(l_score);
  assign r_inc = bcd_inc(r_score);
  assign blank_l = (st == OVER) && !show && win_left;
  assign blank_r = (st == OVER) && !show && !win_left;
  seg7_decode u_lu (.bcd(l_score[3:0]), .seg(seg_lu));
  seg7_decode u_lt (.bcd(l_score[7:4]), .seg(seg_lt));
  seg7_decode u_ru (.bcd(r_score[3:0]), .seg(seg_ru));
  seg7_decode u_rt (.bcd(r_score[7:4]), .seg(seg_rt));
  // start key resynchronised, then a registered falling-edge pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      {s0, s1, s2, press} <= 4'b1110;
    end else begin
      s0 <= start_n;
      s1 <= s0;
      s2 <= s1;
      press <= s2 & ~s1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      step <= 1'b0;
      ball_reset <= 1'b1;
      serve_dir <= 1'b0;
      game_over <= 1'b0;
      serve_cnt <= 8'd0;
      blink_cnt <= 8'd0;
      l_score <= 8'd0;
      r_score <= 8'd0;
      rem <= 3'd0;
      show <= 1'b1;
      win_left <= 1'b0;
    end else begin
      step <= 1'b0;
      case (st)
        IDLE: if (press) begin
          st <= SERVE;
          serve_dir <= 1'b0;
          serve_cnt <= 8'd0;
        end
        SERVE: if (frame_tick) begin
          if (serve_cnt == SERVE_LAST) begin
            st <= PLAY;
            ball_reset <= 1'b0;
            rem <= 3'd0;
          end else begin
            serve_cnt <= serve_cnt + 8'd1;
          end
        end
        PLAY: if (point_r || point_l) begin
          // a simultaneous point_l is dropped: the left player's point wins
          rem <= 3'd0;
          ball_reset <= 1'b1;
          serve_cnt <= 8'd0;
          serve_dir <= point_r;
          if (point_r) l_score <= l_inc;
          else r_score <= r_inc;
          if ((point_r ? l_inc : r_inc) == WIN_BCD) begin
            st <= OVER;
            game_over <= 1'b1;
            blink_cnt <= 8'd0;
            show <= 1'b1;
            win_left <= point_r;
          end else begin
            st <= SERVE;
          end
        end else if (step && rem != 3'd0) begin
          step <= 1'b1;
          rem <= rem - 3'd1;
        end else if (frame_tick && !step) begin
          step <= 1'b1;
          rem <= STEPS_LAST;
        end
        OVER: if (press) begin
          st <= SERVE;
          l_score <= 8'd0;
          r_score <= 8'd0;
          serve_dir <= 1'b0;
          serve_cnt <= 8'd0;
          game_over <= 1'b0;
        end else if (frame_tick) begin
          blink_cnt <= (blink_cnt == BLINK_LAST) ? 8'd0 : blink_cnt + 8'd1;
          if (blink_cnt == BLINK_LAST) show <= ~show;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {HEX0, HEX1, HEX4, HEX5} <= {4{SEG_0}};
      {HEX2, HEX3} <= {2{SEG_DASH}};
    end else begin
      HEX0 <= blank_l ? SEG_BLANK : seg_lu;
      HEX1 <= blank_l ? SEG_BLANK : seg_lt;
      HEX4 <= blank_r ? SEG_BLANK : seg_ru;
      HEX5 <= blank_r ? SEG_BLANK : seg_rt;
      HEX3 <= (st == IDLE) ? SEG_DASH : (st == OVER) ? SEG_G : SEG_BLANK;
      HEX2 <= (st == IDLE) ? SEG_DASH : (st == OVER) ? SEG_0 : SEG_BLANK;
    end
  end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed game scenarios plus random play checked against an event-level game model
module tb_pong_game_ctrl;
  localparam int STEPS = 2;
  localparam int SERVE_FRAMES = 60;
  localparam int WIN_SCORE = 11;
  localparam int BLINK_FRAMES = 32;
  localparam logic [6:0] DIG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [6:0] DASH = 7'h3F;
  localparam logic [6:0] BLANK = 7'h7F;
  logic clk = 0, reset = 1, frame_tick = 0, start_n = 1, point_l = 0, point_r = 0;
  logic step, ball_reset, serve_dir, game_over;
  logic [1:0] state;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  int checks = 0, failures = 0;
  // game model: 0 idle, 1 serve, 2 play, 3 over
  int m_mode, m_l, m_r, m_serve, m_over, b_s, b_e, cyc = 0;
  bit m_dir, m_winl, m_step;
  logic [4:0] hist;
  logic [6:0] e_h [6];

  pong_game_ctrl #(.STEPS(STEPS), .SERVE_FRAMES(SERVE_FRAMES), .WIN_SCORE(WIN_SCORE), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_n(start_n), .point_l(point_l), .point_r(point_r),
    .step(step), .ball_reset(ball_reset), .serve_dir(serve_dir), .game_over(game_over), .state(state),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_l = 0; m_r = 0; m_serve = 0; m_over = 0; b_s = 0; b_e = -1;
    m_dir = 0; m_winl = 0; m_step = 0; hist = 5'h1F;
    e_h[0] = DIG[0]; e_h[1] = DIG[0]; e_h[4] = DIG[0]; e_h[5] = DIG[0]; e_h[2] = DASH; e_h[3] = DASH;
  endtask

  task automatic model_edge(input bit ft, input bit pl, input bit pr, input bit sn);
    bit press, blank;
    int e;
    e = cyc;
    press = !hist[2] && hist[3];
    blank = m_mode == 3 && ((m_over / BLINK_FRAMES) % 2 == 1);
    e_h[0] = (blank && m_winl) ? BLANK : DIG[m_l % 10];
    e_h[1] = (blank && m_winl) ? BLANK : DIG[m_l / 10];
    e_h[4] = (blank && !m_winl) ? BLANK : DIG[m_r % 10];
    e_h[5] = (blank && !m_winl) ? BLANK : DIG[m_r / 10];
    e_h[3] = m_mode == 0 ? DASH : m_mode == 3 ? 7'h02 : BLANK;
    e_h[2] = m_mode == 0 ? DASH : m_mode == 3 ? 7'h40 : BLANK;
    case (m_mode)
      0: if (press) begin m_mode = 1; m_dir = 0; m_serve = 0; end
      1: if (ft) begin m_serve++; if (m_serve == SERVE_FRAMES) m_mode = 2; end
      2: if (pr || pl) begin
        if (pr) begin m_l++; m_dir = 1; end else begin m_r++; m_dir = 0; end
        b_e = e - 1;
        m_winl = pr;
        m_serve = 0; m_over = 0;
        m_mode = ((pr ? m_l : m_r) == WIN_SCORE) ? 3 : 1;
      end else if (ft && !m_step) begin
        b_s = e; b_e = e + STEPS - 1;
      end
      default: if (press) begin
        m_l = 0; m_r = 0; m_dir = 0; m_mode = 1; m_serve = 0;
      end else if (ft) m_over++;
    endcase
    m_step = e >= b_s && e <= b_e;
    hist = {hist[3:0], sn};
    cyc++;
  endtask

  task automatic tick(input logic ft, input logic pl, input logic pr, input logic sn);
    frame_tick = ft; point_l = pl; point_r = pr; start_n = sn;
    @(posedge clk);
    model_edge(ft, pl, pr, sn);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 1);
  endtask

  task automatic do_reset();
    frame_tick = 0; point_l = 0; point_r = 0; start_n = 1; reset = 1;
    @(posedge clk);
    model_reset();
    cyc++;
    #1;
    reset = 0;
  endtask

  task automatic serve_to_play();
    repeat (SERVE_FRAMES) begin tick(1, 0, 0, 1); idle(2); end
  endtask

  task automatic test_reset();
    bit stepped;
    do_reset();
    checks++; if ({state, step, ball_reset, serve_dir, game_over} !== 6'b000100) begin failures++; $display("FAIL reset_ctrl got=%b exp=000100", {state, step, ball_reset, serve_dir, game_over}); end
    checks++; if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {DIG[0], DIG[0], DASH, DASH, DIG[0], DIG[0]}) begin failures++; $display("FAIL reset_hex got=%h", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}); end
    stepped = 0;
    repeat (3) begin tick(1, 0, 0, 1); stepped |= step; tick(0, 1, 1, 1); stepped |= step; end
    checks++; if (stepped !== 1'b0) begin failures++; $display("FAIL idle_no_step got=%b exp=0", stepped); end
    checks++; if ({HEX0, HEX2, ball_reset, state} !== {DIG[0], DASH, 1'b1, 2'd0}) begin failures++; $display("FAIL idle_hold got=%h %h %b %0d", HEX0, HEX2, ball_reset, state); end
  endtask

  task automatic test_start();
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 0);
      if (i == 2) begin checks++; if (state !== 2'd0) begin failures++; $display("FAIL press_early got=%0d exp=0", state); end end
      if (i == 3) begin checks++; if (state !== 2'd1) begin failures++; $display("FAIL press_serve got=%0d exp=1", state); end end
    end
    tick(0, 0, 0, 0); tick(0, 0, 0, 1); idle(2);
    tick(0, 0, 0, 0); idle(4);
    repeat (SERVE_FRAMES - 1) begin tick(1, 0, 0, 1); idle(2); end
    checks++; if ({state, ball_reset} !== {2'd1, 1'b1}) begin failures++; $display("FAIL serve_hold got=%0d/%b exp=1/1", state, ball_reset); end
    tick(1, 0, 0, 1);
    checks++; if ({state, ball_reset, step} !== {2'd2, 1'b0, 1'b0}) begin failures++; $display("FAIL serve_to_play got=%0d/%b/%b exp=2/0/0", state, ball_reset, step); end
    idle(3);
    tick(1, 0, 0, 1);
    checks++; if (step !== 1'b1) begin failures++; $display("FAIL burst_t1 got=%b exp=1", step); end
    tick(1, 0, 0, 1);
    checks++; if (step !== 1'b1) begin failures++; $display("FAIL burst_t2 got=%b exp=1", step); end
    idle(1);
    checks++; if (step !== 1'b0) begin failures++; $display("FAIL burst_end got=%b exp=0", step); end
  endtask

  task automatic test_points();
    tick(0, 0, 1, 1);
    checks++; if ({state, serve_dir, ball_reset, HEX0} !== {2'd1, 1'b1, 1'b1, DIG[0]}) begin failures++; $display("FAIL point_r_t1 got=%0d/%b/%b/%h", state, serve_dir, ball_reset, HEX0); end
    idle(1);
    checks++; if (HEX0 !== DIG[1]) begin failures++; $display("FAIL point_r_hex got=%h exp=%h", HEX0, DIG[1]); end
    serve_to_play();
    tick(0, 1, 1, 1); idle(1);
    checks++; if ({HEX0, HEX4, serve_dir} !== {DIG[2], DIG[0], 1'b1}) begin failures++; $display("FAIL both_points got=%h/%h/%b", HEX0, HEX4, serve_dir); end
    serve_to_play();
    tick(1, 0, 0, 1);
    tick(0, 0, 1, 1);
    checks++; if (step !== 1'b0) begin failures++; $display("FAIL burst_abort got=%b exp=0", step); end
    serve_to_play();
    tick(0, 1, 0, 1); idle(1);
    checks++; if ({HEX4, HEX0, serve_dir} !== {DIG[1], DIG[3], 1'b0}) begin failures++; $display("FAIL point_l got=%h/%h/%b", HEX4, HEX0, serve_dir); end
  endtask

  task automatic test_win();
    bit stepped;
    for (int n = 0; n < 20 && m_l < 9; n++) begin serve_to_play(); tick(0, 0, 1, 1); end
    serve_to_play(); tick(0, 0, 1, 1); idle(1);
    checks++; if ({HEX1, HEX0, state} !== {DIG[1], DIG[0], 2'd1}) begin failures++; $display("FAIL bcd_carry got=%h/%h/%0d", HEX1, HEX0, state); end
    serve_to_play(); tick(0, 0, 1, 1);
    checks++; if ({state, game_over, ball_reset} !== {2'd3, 1'b1, 1'b1}) begin failures++; $display("FAIL win_over got=%0d/%b/%b", state, game_over, ball_reset); end
    idle(1);
    checks++; if ({HEX3, HEX2, HEX1, HEX0} !== {7'h02, 7'h40, DIG[1], DIG[1]}) begin failures++; $display("FAIL over_hex got=%h", {HEX3, HEX2, HEX1, HEX0}); end
    stepped = 0;
    repeat (BLINK_FRAMES) begin tick(1, 0, 0, 1); stepped |= step; idle(1); end
    checks++; if ({HEX1, HEX0, HEX4} !== {BLANK, BLANK, DIG[1]}) begin failures++; $display("FAIL blink_off got=%h/%h/%h", HEX1, HEX0, HEX4); end
    repeat (BLINK_FRAMES) begin tick(1, 0, 0, 1); stepped |= step; idle(1); end
    checks++; if ({HEX1, HEX0} !== {DIG[1], DIG[1]}) begin failures++; $display("FAIL blink_on got=%h/%h", HEX1, HEX0); end
    checks++; if (stepped !== 1'b0) begin failures++; $display("FAIL over_no_step got=%b exp=0", stepped); end
  endtask

  task automatic test_over_press();
    tick(0, 0, 0, 0); idle(3);
    checks++; if ({state, game_over, serve_dir} !== {2'd1, 1'b0, 1'b0}) begin failures++; $display("FAIL over_press got=%0d/%b/%b", state, game_over, serve_dir); end
    idle(1);
    checks++; if ({HEX1, HEX0, HEX5, HEX4} !== {4{DIG[0]}}) begin failures++; $display("FAIL over_clear got=%h", {HEX1, HEX0, HEX5, HEX4}); end
  endtask

  task automatic test_reset_mid_burst();
    serve_to_play(); tick(0, 0, 1, 1);
    serve_to_play(); tick(1, 0, 0, 1);
    checks++; if (step !== 1'b1) begin failures++; $display("FAIL pre_reset_burst got=%b exp=1", step); end
    do_reset();
    checks++; if ({step, state, ball_reset, HEX0, HEX2} !== {1'b0, 2'd0, 1'b1, DIG[0], DASH}) begin failures++; $display("FAIL reset_mid got=%b/%0d/%b/%h/%h", step, state, ball_reset, HEX0, HEX2); end
    idle(1);
    checks++; if (step !== 1'b0) begin failures++; $display("FAIL reset_burst_dead got=%b exp=0", step); end
  endtask

  task automatic test_random();
    int low_left, shown;
    logic ft, pl, pr, sn;
    logic [51:0] act, expv;
    low_left = 0; shown = 0;
    do_reset();
    for (int i = 0; i < 9000; i++) begin
      ft = ($urandom % 4) == 0;
      pr = ($urandom % 40) == 0;
      pl = ($urandom % 90) == 0;
      if (low_left == 0 && ($urandom % 300) == 0) low_left = $urandom_range(1, 6);
      sn = (low_left == 0);
      if (low_left != 0) low_left--;
      tick(ft, pl, pr, sn);
      act = {state, step, ball_reset, serve_dir, game_over, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
      expv = {2'(m_mode), m_step, m_mode != 2, m_dir, m_mode == 3, e_h[5], e_h[4], e_h[3], e_h[2], e_h[1], e_h[0]};
      checks++;
      if (act !== expv) begin
        failures++;
        if (shown < 10) begin shown++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act, expv); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_points();
    test_win();
    test_over_press();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
